// File: rtl/regfile_sb.sv
// Register file with a per-register pending-write scoreboard, hazard detection and a sticky stray-writeback flag.
// Optional feature: define REGFILE_BYPASS_EN to forward writeback data to the read ports and hide pending-under-writeback.
module regfile_sb #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        rd1_addr,
    input  logic [ADDR_W-1:0]        rd2_addr,
    input  logic                     rd1_en,
    input  logic                     rd2_en,
    output logic [DATA_W-1:0]        rd1_data,
    output logic [DATA_W-1:0]        rd2_data,
    input  logic                     iss_vld,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     wb_we,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [DATA_W-1:0]        wb_data,
    output logic                     hazard,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic [ADDR_W:0]          pend_cnt,
    output logic                     wb_err
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [NREG-1:0]   r_busy;
    logic [ADDR_W:0]   r_pend_cnt;
    logic              r_wb_err;

    logic [NREG-1:0]   w_busy_nxt;
    logic              w_wb_eff;
    logic              w_iss_acc;
    logic              w_err_set;
    logic              w_pend1;
    logic              w_pend2;
    logic              w_pend_iss;

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    function automatic logic [ADDR_W:0] popcount(input logic [NREG-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + (ADDR_W+1)'(v[i]);
        end
        return c;
    endfunction

    // Pending view used by the hazard check; with bypass a register being written back this cycle is already resolved.
    always_comb begin
        w_pend1    = r_busy[rd1_addr];
        w_pend2    = r_busy[rd2_addr];
        w_pend_iss = r_busy[iss_addr];
`ifdef REGFILE_BYPASS_EN
        if (wb_we && (wb_addr == rd1_addr)) w_pend1    = 1'b0;
        if (wb_we && (wb_addr == rd2_addr)) w_pend2    = 1'b0;
        if (wb_we && (wb_addr == iss_addr)) w_pend_iss = 1'b0;
`endif
    end

    assign hazard    = (rd1_en & w_pend1) | (rd2_en & w_pend2) | (iss_vld & w_pend_iss);
    assign w_wb_eff  = wb_we & ~is_zero_reg(wb_addr);
    assign w_iss_acc = iss_vld & ~hazard & ~is_zero_reg(iss_addr);

    // A writeback paired with a same-cycle accepted issue of that register is expected traffic, not a stray write.
    assign w_err_set = w_wb_eff & ~r_busy[wb_addr] & ~(w_iss_acc & (iss_addr == wb_addr));

    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wb_eff)  w_busy_nxt[wb_addr]  = 1'b0;
        if (w_iss_acc) w_busy_nxt[iss_addr] = 1'b1;
    end

    always_comb begin
        rd1_data = r_regs[rd1_addr];
        rd2_data = r_regs[rd2_addr];
`ifdef REGFILE_BYPASS_EN
        if (w_wb_eff && (wb_addr == rd1_addr)) rd1_data = wb_data;
        if (w_wb_eff && (wb_addr == rd2_addr)) rd2_data = wb_data;
`endif
        if (is_zero_reg(rd1_addr)) rd1_data = '0;
        if (is_zero_reg(rd2_addr)) rd2_data = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_eff) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
            r_wb_err   <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= popcount(w_busy_nxt);
            if (w_err_set) r_wb_err <= 1'b1;
        end
    end

    assign busy     = r_busy;
    assign pend_cnt = r_pend_cnt;
    assign wb_err   = r_wb_err;

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus queues expected values, a negedge monitor pops and compares them.
// Three instances: default, ZERO_REG=1, and DATA_W=16/ADDR_W=3.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] a_rd1_addr, a_rd2_addr, a_iss_addr, a_wb_addr;
    logic       a_rd1_en, a_rd2_en, a_iss_vld, a_wb_we;
    logic [7:0] a_wb_data, a_rd1_data, a_rd2_data;
    logic       a_hazard, a_wb_err;
    logic [3:0] a_busy;
    logic [2:0] a_pend;

    logic [1:0] z_rd1_addr, z_rd2_addr, z_iss_addr, z_wb_addr;
    logic       z_rd1_en, z_rd2_en, z_iss_vld, z_wb_we;
    logic [7:0] z_wb_data, z_rd1_data, z_rd2_data;
    logic       z_hazard, z_wb_err;
    logic [3:0] z_busy;
    logic [2:0] z_pend;

    logic [2:0]  w_rd1_addr, w_rd2_addr, w_iss_addr, w_wb_addr;
    logic        w_rd1_en, w_rd2_en, w_iss_vld, w_wb_we;
    logic [15:0] w_wb_data, w_rd1_data, w_rd2_data;
    logic        w_hazard, w_wb_err;
    logic [7:0]  w_busy;
    logic [3:0]  w_pend;

    regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(0)) u_a (
        .clk(clk), .rst(rst),
        .rd1_addr(a_rd1_addr), .rd2_addr(a_rd2_addr), .rd1_en(a_rd1_en), .rd2_en(a_rd2_en),
        .rd1_data(a_rd1_data), .rd2_data(a_rd2_data),
        .iss_vld(a_iss_vld), .iss_addr(a_iss_addr),
        .wb_we(a_wb_we), .wb_addr(a_wb_addr), .wb_data(a_wb_data),
        .hazard(a_hazard), .busy(a_busy), .pend_cnt(a_pend), .wb_err(a_wb_err)
    );

    regfile_sb #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1)) u_z (
        .clk(clk), .rst(rst),
        .rd1_addr(z_rd1_addr), .rd2_addr(z_rd2_addr), .rd1_en(z_rd1_en), .rd2_en(z_rd2_en),
        .rd1_data(z_rd1_data), .rd2_data(z_rd2_data),
        .iss_vld(z_iss_vld), .iss_addr(z_iss_addr),
        .wb_we(z_wb_we), .wb_addr(z_wb_addr), .wb_data(z_wb_data),
        .hazard(z_hazard), .busy(z_busy), .pend_cnt(z_pend), .wb_err(z_wb_err)
    );

    regfile_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0)) u_w (
        .clk(clk), .rst(rst),
        .rd1_addr(w_rd1_addr), .rd2_addr(w_rd2_addr), .rd1_en(w_rd1_en), .rd2_en(w_rd2_en),
        .rd1_data(w_rd1_data), .rd2_data(w_rd2_data),
        .iss_vld(w_iss_vld), .iss_addr(w_iss_addr),
        .wb_we(w_wb_we), .wb_addr(w_wb_addr), .wb_data(w_wb_data),
        .hazard(w_hazard), .busy(w_busy), .pend_cnt(w_pend), .wb_err(w_wb_err)
    );

    localparam int A_RD1 = 0, A_RD2 = 1, A_HAZ = 2, A_BUSY = 3, A_PEND = 4, A_ERR = 5;
    localparam int Z_RD1 = 6, Z_ERR = 7, Z_BUSY = 8;
    localparam int W_PEND = 9, W_BUSY = 10, W_HAZ = 11, W_RD1 = 12;

    typedef struct {
        string       name;
        int          id;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic expect_v(input string n, input int id, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.id   = id;
        e.exp  = v;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] actual(input int id);
        case (id)
            A_RD1:  return 32'(a_rd1_data);
            A_RD2:  return 32'(a_rd2_data);
            A_HAZ:  return 32'(a_hazard);
            A_BUSY: return 32'(a_busy);
            A_PEND: return 32'(a_pend);
            A_ERR:  return 32'(a_wb_err);
            Z_RD1:  return 32'(z_rd1_data);
            Z_ERR:  return 32'(z_wb_err);
            Z_BUSY: return 32'(z_busy);
            W_PEND: return 32'(w_pend);
            W_BUSY: return 32'(w_busy);
            W_HAZ:  return 32'(w_hazard);
            W_RD1:  return 32'(w_rd1_data);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    exp_t        m_e;
    logic [31:0] m_act;
    always @(negedge clk) begin
        while (sb.size() != 0) begin
            m_e   = sb.pop_front();
            m_act = actual(m_e.id);
            total = total + 1;
            if (m_act !== m_e.exp) begin
                bad = bad + 1;
                $display("FAIL %s: got 0x%0h want 0x%0h", m_e.name, m_act, m_e.exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_all();
        a_rd1_addr = '0; a_rd2_addr = '0; a_iss_addr = '0; a_wb_addr = '0;
        a_rd1_en = 0; a_rd2_en = 0; a_iss_vld = 0; a_wb_we = 0; a_wb_data = '0;
        z_rd1_addr = '0; z_rd2_addr = '0; z_iss_addr = '0; z_wb_addr = '0;
        z_rd1_en = 0; z_rd2_en = 0; z_iss_vld = 0; z_wb_we = 0; z_wb_data = '0;
        w_rd1_addr = '0; w_rd2_addr = '0; w_iss_addr = '0; w_wb_addr = '0;
        w_rd1_en = 0; w_rd2_en = 0; w_iss_vld = 0; w_wb_we = 0; w_wb_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_all();
        step();
        step();
        rst = 1'b1;
        a_rd1_addr = 2'd1;
        expect_v("rst_rd1", A_RD1, 32'h0);
        expect_v("rst_haz", A_HAZ, 32'h0);
        expect_v("rst_busy", A_BUSY, 32'h0);
        expect_v("rst_pend", A_PEND, 32'h0);
        expect_v("rst_err", A_ERR, 32'h0);

        // Write 0xA5 to r1 while issuing r3, then reset asynchronously mid-cycle.
        step();
        a_iss_vld = 1; a_iss_addr = 2'd1;
        step();
        a_iss_addr = 2'd3;
        a_wb_we = 1; a_wb_addr = 2'd1; a_wb_data = 8'hA5;
        expect_v("iss_busy", A_BUSY, 32'h2);
        step();
        idle_all();
        a_rd1_addr = 2'd1;
        expect_v("wr_rd1", A_RD1, 32'hA5);
        expect_v("wr_busy", A_BUSY, 32'h8);
        expect_v("wr_pend", A_PEND, 32'h1);
        expect_v("wr_err", A_ERR, 32'h0);
        drain();
        rst = 1'b0;
        expect_v("arst_rd1", A_RD1, 32'h0);
        expect_v("arst_busy", A_BUSY, 32'h0);
        expect_v("arst_pend", A_PEND, 32'h0);
        drain();
        rst = 1'b1;

        // Scoreboard hazard on r2, then writeback 0x3C.
        step();
        a_iss_vld = 1; a_iss_addr = 2'd2;
        expect_v("iss2_haz", A_HAZ, 32'h0);
        step();
        a_iss_vld = 0;
        a_rd1_en = 1; a_rd1_addr = 2'd2;
        expect_v("sb_haz", A_HAZ, 32'h1);
        expect_v("sb_busy", A_BUSY, 32'h4);
        expect_v("sb_pend", A_PEND, 32'h1);
        step();
        a_wb_we = 1; a_wb_addr = 2'd2; a_wb_data = 8'h3C;
`ifdef REGFILE_BYPASS_EN
        expect_v("sb_wb_haz", A_HAZ, 32'h0);
        expect_v("sb_wb_rd1", A_RD1, 32'h3C);
`else
        expect_v("sb_wb_haz", A_HAZ, 32'h1);
        expect_v("sb_wb_rd1", A_RD1, 32'h0);
`endif
        step();
        a_wb_we = 0;
        expect_v("sb_done_busy", A_BUSY, 32'h0);
        expect_v("sb_done_pend", A_PEND, 32'h0);
        expect_v("sb_done_rd1", A_RD1, 32'h3C);
        expect_v("sb_done_haz", A_HAZ, 32'h0);
        expect_v("sb_done_err", A_ERR, 32'h0);
        a_rd1_en = 0;

        // Bypass: r3 holds 0x55, pending again, written 0x7E while read on port 2.
        step();
        a_iss_vld = 1; a_iss_addr = 2'd3;
        step();
        a_iss_vld = 0;
        a_wb_we = 1; a_wb_addr = 2'd3; a_wb_data = 8'h55;
        step();
        a_wb_we = 0;
        a_iss_vld = 1; a_iss_addr = 2'd3;
        step();
        a_iss_vld = 0;
        a_wb_we = 1; a_wb_addr = 2'd3; a_wb_data = 8'h7E;
        a_rd2_en = 1; a_rd2_addr = 2'd3;
`ifdef REGFILE_BYPASS_EN
        expect_v("byp_rd2", A_RD2, 32'h7E);
        expect_v("byp_haz", A_HAZ, 32'h0);
`else
        expect_v("byp_rd2", A_RD2, 32'h55);
        expect_v("byp_haz", A_HAZ, 32'h1);
`endif
        step();
        a_wb_we = 0;
        expect_v("byp_after_rd2", A_RD2, 32'h7E);
        expect_v("byp_after_busy", A_BUSY, 32'h0);
        expect_v("byp_after_haz", A_HAZ, 32'h0);
        a_rd2_en = 0;

        // Collision: issue r1 and writeback r1 in the same cycle.
        step();
        a_iss_vld = 1; a_iss_addr = 2'd1;
        a_wb_we = 1; a_wb_addr = 2'd1; a_wb_data = 8'h11;
        step();
        a_iss_vld = 0; a_wb_we = 0;
        a_rd1_addr = 2'd1;
        expect_v("col_busy", A_BUSY, 32'h2);
        expect_v("col_pend", A_PEND, 32'h1);
        expect_v("col_rd1", A_RD1, 32'h11);
        expect_v("col_err", A_ERR, 32'h0);
        step();
        a_wb_we = 1; a_wb_addr = 2'd1; a_wb_data = 8'h22;
        step();
        a_wb_we = 0;
        expect_v("ret_busy", A_BUSY, 32'h0);
        expect_v("ret_rd1", A_RD1, 32'h22);
        expect_v("ret_err", A_ERR, 32'h0);

        // Stray writeback to r2 sets the sticky error.
        step();
        a_wb_we = 1; a_wb_addr = 2'd2; a_wb_data = 8'h99;
        step();
        a_wb_we = 0;
        a_rd1_addr = 2'd2;
        expect_v("err_set", A_ERR, 32'h1);
        expect_v("err_rd1", A_RD1, 32'h99);
        step();
        step();
        expect_v("err_sticky", A_ERR, 32'h1);
        drain();
        rst = 1'b0;
        expect_v("err_clr", A_ERR, 32'h0);
        drain();
        rst = 1'b1;

        // ZERO_REG=1: r0 ignores writes and issues; r1 still works.
        step();
        z_wb_we = 1; z_wb_addr = 2'd0; z_wb_data = 8'hFF;
        z_iss_vld = 1; z_iss_addr = 2'd0;
        z_rd1_addr = 2'd0;
        step();
        z_wb_we = 0; z_iss_vld = 0;
        expect_v("z_rd0", Z_RD1, 32'h0);
        expect_v("z_err", Z_ERR, 32'h0);
        expect_v("z_busy", Z_BUSY, 32'h0);
        z_iss_vld = 1; z_iss_addr = 2'd1;
        step();
        z_iss_vld = 0;
        z_wb_we = 1; z_wb_addr = 2'd1; z_wb_data = 8'h44;
        expect_v("z_busy1", Z_BUSY, 32'h2);
        step();
        z_wb_we = 0;
        z_rd1_addr = 2'd1;
        expect_v("z_rd1", Z_RD1, 32'h44);
        expect_v("z_err1", Z_ERR, 32'h0);

        // Wide instance: fill all eight busy bits, then retire them.
        for (int i = 0; i < 8; i++) begin
            step();
            w_iss_vld = 1; w_iss_addr = 3'(i);
            expect_v("w_fill_pend", W_PEND, 32'(i));
            expect_v("w_fill_haz", W_HAZ, 32'h0);
        end
        step();
        w_iss_vld = 0;
        expect_v("w_full_pend", W_PEND, 32'h8);
        expect_v("w_full_busy", W_BUSY, 32'hFF);
        for (int i = 0; i < 8; i++) begin
            step();
            w_wb_we = 1; w_wb_addr = 3'(i); w_wb_data = 16'h1000 + 16'(i);
            expect_v("w_ret_pend", W_PEND, 32'(8 - i));
        end
        step();
        w_wb_we = 0;
        w_rd1_addr = 3'd5;
        expect_v("w_empty_pend", W_PEND, 32'h0);
        expect_v("w_empty_busy", W_BUSY, 32'h0);
        expect_v("w_rd5", W_RD1, 32'h1005);

        drain();
        if (sb.size() != 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL sb_left: got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 2, register index width; depth NREG = 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 0, 1 = register 0 hardwired to zero.
REQ-004 clk  in  1  single clock; all state updates on posedge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 rd1_addr, rd2_addr  in  ADDR_W each  read port indices.
REQ-007 rd1_en, rd2_en  in  1 each  read port used by the current ID instruction.
REQ-008 rd1_data, rd2_data  out  DATA_W each  combinational read data.
REQ-009 iss_vld, iss_addr  in  1 / ADDR_W  ID issues an instruction that will write iss_addr.
REQ-010 wb_we, wb_addr, wb_data  in  1 / ADDR_W / DATA_W  writeback port.
REQ-011 hazard  out  1  current ID read or issue conflicts with a pending write; ID must stall.
REQ-012 busy  out  NREG  per-register pending-write scoreboard.
REQ-013 pend_cnt  out  ADDR_W+1  number of set busy bits.
REQ-014 wb_err  out  1  sticky: writeback to a register with no pending write.

Function
REQ-015 Write: on posedge clk with wb_we=1, reg[wb_addr] <= wb_data; one write per cycle.
REQ-016 Read: rdN_data = reg[rdN_addr] combinationally; address 0 reads 0 when ZERO_REG=1.
REQ-017 ZERO_REG=1: writes and issues to address 0 are ignored; busy[0] stays 0; no wb_err for address 0.
REQ-018 hazard = (rd1_en & pend(rd1_addr)) | (rd2_en & pend(rd2_addr)) | (iss_vld & pend(iss_addr)); pend() defined in REQ-029/030.
REQ-019 Issue accepted only when iss_vld=1 and hazard=0; accepted issue sets busy[iss_addr] at the next posedge.
REQ-020 wb_we=1 clears busy[wb_addr] at the next posedge.
REQ-021 Same-cycle accepted issue and wb_we to the same address: busy stays 1 (issue wins); data still written.
REQ-022 Issue and wb to different addresses in the same cycle: both take effect.
REQ-023 pend_cnt = popcount(busy), registered, updated together with busy; range 0..NREG, no wrap.
REQ-024 wb_we=1 to an address with busy=0 (excluding REQ-017) sets wb_err at the next posedge; data is still written.
REQ-025 Latency: write visible on read ports the cycle after the write edge (or same cycle per REQ-029).

Reset
REQ-026 rst=0 asynchronously clears all registers to 0, busy to 0, pend_cnt to 0, wb_err to 0.
REQ-027 Reset mid-operation discards pending issues and in-flight writes; the first posedge after release behaves as from idle.
REQ-028 Outputs immediately after reset: rdN_data=0, hazard=0, busy=0, pend_cnt=0, wb_err=0.

Configuration
REQ-029 With REGFILE_BYPASS_EN defined: when wb_we=1 and wb_addr=rdN_addr, rdN_data = wb_data in the same cycle, and pend(a) = busy[a] & ~(wb_we & wb_addr==a).
REQ-030 Without REGFILE_BYPASS_EN: rdN_data always returns stored value and pend(a) = busy[a]; a read of a register under writeback stalls one extra cycle.

Verification
REQ-031 Reset: write 0xA5 to r1, assert rst=0 mid-cycle -> r1 reads 0x00, busy=0, pend_cnt=0 asynchronously.
REQ-032 Scoreboard: issue r2, next cycle rd1_en=1 rd1_addr=2 -> hazard=1, busy=0b0100, pend_cnt=1; wb_we r2=0x3C -> busy=0, read returns 0x3C.
REQ-033 Bypass: busy[3]=1, same cycle wb_we r3=0x7E and rd2_addr=3 -> with macro rd2_data=0x7E, hazard=0; without macro rd2_data=old value, hazard=1.
REQ-034 Collision: accepted issue r1 and wb_we r1=0x11 same cycle -> busy[1]=1, r1=0x11, wb_err=0.
REQ-035 Error: wb_we to r2 with busy[2]=0 -> wb_err=1 and stays 1 until reset; ZERO_REG=1 write 0xFF to r0 -> r0 reads 0x00, wb_err=0.
REQ-036 Parametrisation: DATA_W=16, ADDR_W=3, issue all 8 registers on successive cycles -> pend_cnt reaches 8 (0b1000), no wrap; retire all -> 0.
